sram_trng_readback: RTL and testbench

Streams a block of stored SRAM-TRNG bytes from the FPGA's single-port RAM back to the microprocessor over an 8-bit parallel bus with a four-phase valid/ack handshake. It is the transmit-direction counterpart of the capture path, which writes microprocessor bytes into the RAM. It sits between the RAM read port and the microprocessor GPIO pins. It is started by a one-cycle command pulse and reports completion with a one-cycle done pulse.

---
 rtl/sram_trng_readback.sv | 105 ++++++++++
 tb/tb_sram_trng_readback.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_trng_readback.sv
// Streams a block of SRAM-TRNG bytes from the single-port RAM to the microprocessor
// over an 8-bit bus using a four-phase valid/ack handshake.
module sram_trng_readback #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   len,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_q,
   output logic [DATA_W-1:0] uproc_dout,
   output logic              uproc_valid,
   input  logic              uproc_ack,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_WAIT = 3'd1,
      RD_CAP  = 3'd2,
      PRESENT = 3'd3,
      RELEASE = 3'd4
   } state_t;

   state_t          state;
   logic [ADDR_W:0] remaining;
   logic            ack_p0;
   logic            ack_s;
   // Set once ack_s has been seen low while a byte is on the bus, so a stale
   // high ack left over from before the byte cannot consume it.
   logic            armed;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ram_addr    <= '0;
         remaining   <= '0;
         uproc_dout  <= '0;
         uproc_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         ack_p0      <= 1'b0;
         ack_s       <= 1'b0;
         armed       <= 1'b0;
      end else begin
         ack_p0 <= uproc_ack;
         ack_s  <= ack_p0;
         done   <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  if (len == '0) begin
                     done <= 1'b1;
                  end else begin
                     ram_addr  <= base_addr;
                     remaining <= len;
                     busy      <= 1'b1;
                     state     <= RD_WAIT;
                  end
               end
            end

            RD_WAIT: state <= RD_CAP;

            RD_CAP: begin
               uproc_dout  <= ram_q;
               uproc_valid <= 1'b1;
               armed       <= ~ack_s;
               state       <= PRESENT;
            end

            PRESENT: begin
               if (!ack_s) begin
                  armed <= 1'b1;
               end else if (armed) begin
                  uproc_valid <= 1'b0;
                  remaining   <= remaining - 1'b1;
                  ram_addr    <= ram_addr + 1'b1;
                  state       <= RELEASE;
               end
            end

            RELEASE: begin
               if (!ack_s) begin
                  if (remaining != '0) begin
                     state <= RD_WAIT;
                  end else begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_trng_readback.sv
// Randomized scoreboard bench for sram_trng_readback: a RAM model, an ack responder
// and a monitor that checks every presented byte against the expected stream.
module tb_sram_trng_readback;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   len;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_q;
   logic [DATA_W-1:0] uproc_dout;
   logic              uproc_valid;
   logic              uproc_ack;
   logic              busy;
   logic              done;

   sram_trng_readback #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
      .ram_addr(ram_addr), .ram_q(ram_q), .uproc_dout(uproc_dout),
      .uproc_valid(uproc_valid), .uproc_ack(uproc_ack), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM
   logic [DATA_W-1:0] mem [DEPTH];
   always @(posedge clk) ram_q <= mem[ram_addr];

   logic manual = 1'b0;
   logic man_ack = 1'b0;
   logic auto_ack = 1'b0;
   int   ack_dly = 3;
   assign uproc_ack = manual ? man_ack : auto_ack;

   logic [DATA_W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass = 0;
   int done_cnt = 0;
   int hs_cnt = 0;
   int ack_cnt = 0;
   logic [ADDR_W-1:0] last_addr = '0;
   logic [DATA_W-1:0] cap = '0;
   logic prev_valid = 1'b0;
   logic prev_done = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Microprocessor ack responder: raises ack ack_dly cycles after valid, drops it when valid falls
   initial begin
      int vcnt;
      vcnt = 0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            auto_ack = 1'b0;
            vcnt = 0;
         end else if (uproc_valid === 1'b1 && !auto_ack) begin
            vcnt++;
            if (vcnt >= ack_dly) begin
               auto_ack = 1'b1;
               vcnt = 0;
            end
         end else if (uproc_valid === 1'b0 && auto_ack) begin
            auto_ack = 1'b0;
         end
      end
   end

   // Monitor: pops the scoreboard on every new byte, checks bus stability and done width
   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         chk("done_width", int'(prev_done), 0);
      end
      if (uproc_valid === 1'b1 && !prev_valid) begin
         hs_cnt++;
         last_addr = ram_addr;
         cap = uproc_dout;
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_byte: got 0x%0h expected none", uproc_dout);
         end else begin
            chk("byte", int'(uproc_dout), int'(exp_q.pop_front()));
         end
      end
      if (uproc_valid === 1'b0 && prev_valid && rst === 1'b0) begin
         ack_cnt++;
         chk("dout_stable", int'(uproc_dout), int'(cap));
      end
      prev_valid = (uproc_valid === 1'b1);
      prev_done  = (done === 1'b1);
   end

   task automatic pulse_start(input int b, input int l);
      @(negedge clk);
      base_addr = ADDR_W'(b);
      len = (ADDR_W+1)'(l);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic xfer(input int b, input int l);
      for (int i = 0; i < l; i++) exp_q.push_back(mem[(b + i) % DEPTH]);
      pulse_start(b, l);
   endtask

   task automatic wait_done(input int budget, input string name);
      int c0;
      c0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == c0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      #1;
      chk(name, done_cnt - c0, 1);
      chk({name, "_queue_empty"}, exp_q.size(), 0);
   endtask

   task automatic wait_hs(input int target, input int budget);
      for (int i = 0; i < budget && hs_cnt < target; i++) @(negedge clk);
      #1;
      chk("hs_reached", int'(hs_cnt >= target), 1);
   endtask

   task automatic wait_valid_low(input int budget, input string name);
      for (int i = 0; i < budget && uproc_valid; i++) @(negedge clk);
      chk(name, int'(uproc_valid), 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int viol, lat, c0, a0, h0, b, l;
      rst = 1'b1;
      start = 1'b0;
      base_addr = '0;
      len = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);

      // Reset and zero-length start
      repeat (4) @(negedge clk);
      chk("rst_ram_addr", int'(ram_addr), 0);
      chk("rst_dout", int'(uproc_dout), 0);
      chk("rst_valid", int'(uproc_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      rst = 1'b0;
      @(negedge clk);
      c0 = done_cnt;
      pulse_start(12'h123, 0);
      chk("len0_done", int'(done), 1);
      chk("len0_busy", int'(busy), 0);
      chk("len0_addr", int'(ram_addr), 0);
      @(negedge clk);
      chk("len0_done_drop", int'(done), 0);
      chk("len0_busy2", int'(busy), 0);
      repeat (3) @(negedge clk);
      #1;
      chk("len0_done_cnt", done_cnt - c0, 1);

      // Basic stream
      for (int i = 0; i < 4; i++) mem[i] = DATA_W'(8'h10 + i);
      ack_dly = 3;
      xfer(0, 4);
      wait_done(300, "basic_done");

      // Wrap-around
      mem[10'h3FE] = 8'hA0; mem[10'h3FF] = 8'hA1; mem[0] = 8'hB0; mem[1] = 8'hB1;
      xfer(10'h3FE, 4);
      wait_done(300, "wrap_done");
      chk("wrap_last_addr", int'(last_addr), 10'h001);

      // Random transfers with random ack latency
      for (int k = 0; k < 4; k++) begin
         b = $urandom_range(0, DEPTH - 1);
         l = $urandom_range(1, 20);
         ack_dly = $urandom_range(1, 6);
         xfer(b, l);
         wait_done(l * 40 + 100, "rand_done");
      end

      // Early and stretched ack
      manual = 1'b1;
      man_ack = 1'b1;
      repeat (4) @(negedge clk);
      xfer(10'h040, 2);
      repeat (20) @(negedge clk);
      chk("early_ack_held_valid", int'(uproc_valid), 1);
      man_ack = 1'b0;
      repeat (4) @(negedge clk);
      man_ack = 1'b1;
      wait_valid_low(10, "early_consume");
      viol = 0;
      repeat (50) begin
         @(negedge clk);
         if (uproc_valid) viol++;
      end
      chk("held_ack_no_next", viol, 0);
      man_ack = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (uproc_valid) begin
            lat = i;
            break;
         end
      end
      chk("next_byte_latency", lat, 5);
      man_ack = 1'b1;
      wait_valid_low(10, "second_consume");
      man_ack = 1'b0;
      wait_done(50, "early_done");
      manual = 1'b0;

      // Start while busy, then reset mid-transfer
      ack_dly = 3;
      #1;
      h0 = hs_cnt;
      xfer(10'h020, 4);
      wait_hs(h0 + 2, 100);
      pulse_start(10'h300, 5);
      wait_hs(h0 + 3, 100);
      chk("valid_before_rst", int'(uproc_valid), 1);
      c0 = done_cnt;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_valid", int'(uproc_valid), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      repeat (20) @(negedge clk);
      #1;
      chk("midrst_no_done", done_cnt - c0, 0);

      // Full depth
      for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
      ack_dly = 1;
      #1;
      a0 = ack_cnt;
      xfer(10'h155, DEPTH);
      wait_done(20000, "full_done");
      chk("full_handshakes", ack_cnt - a0, DEPTH);
      chk("full_last_addr", int'(last_addr), 10'h154);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
